// File: rtl/vga_timing_gen_if.sv
// Pixel-side bundle of the VGA timing generator: colour in, swap request in,
// raster counters, sync, data enable, colour and frame/swap pulses out.
interface vga_timing_gen_if #(
    parameter int CW       = 10,
    parameter int R_IN     = 3,
    parameter int G_IN     = 3,
    parameter int B_IN     = 2,
    parameter int OUT_BITS = 4
);
    logic [R_IN-1:0]     input_red;
    logic [G_IN-1:0]     input_green;
    logic [B_IN-1:0]     input_blue;
    logic                swap_req;

    logic [CW-1:0]       hc_out;
    logic [CW-1:0]       vc_out;
    logic                hsync;
    logic                vsync;
    logic                de;
    logic [OUT_BITS-1:0] red;
    logic [OUT_BITS-1:0] green;
    logic [OUT_BITS-1:0] blue;
    logic                frame_start;
    logic                swap_ack;

    // Timing generator side
    modport master (
        input  input_red, input_green, input_blue, swap_req,
        output hc_out, vc_out, hsync, vsync, de,
        output red, green, blue, frame_start, swap_ack
    );

    // Pixel source / double-buffer side
    modport slave (
        output input_red, input_green, input_blue, swap_req,
        input  hc_out, vc_out, hsync, vsync, de,
        input  red, green, blue, frame_start, swap_ack
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster generator with registered sync/colour output stage
// and a vertical-blank buffer-swap grant. Counters advance on the same edge
// that samples the colour for the current (hc, vc), so every registered
// output shows that pixel exactly one cycle later and stays mutually aligned.
module vga_timing_gen #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int HSYNC_POL = 0,
    parameter int VSYNC_POL = 0,
    parameter int R_IN      = 3,
    parameter int G_IN      = 3,
    parameter int B_IN      = 2,
    parameter int OUT_BITS  = 4
) (
    input  logic              vgaclk,
    input  logic              rst,
    vga_timing_gen_if.master  bus
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int CW      = $clog2((H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL);

    localparam logic [CW-1:0] C_H_LAST     = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] C_V_LAST     = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] C_H_ACT      = CW'(H_ACTIVE);
    localparam logic [CW-1:0] C_V_ACT      = CW'(V_ACTIVE);
    localparam logic [CW-1:0] C_V_ACT_LAST = CW'(V_ACTIVE - 1);
    localparam logic [CW-1:0] C_HS_START   = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] C_HS_END     = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] C_VS_START   = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] C_VS_END     = CW'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic C_HS_ON  = (HSYNC_POL != 0);
    localparam logic C_HS_OFF = ~C_HS_ON;
    localparam logic C_VS_ON  = (VSYNC_POL != 0);
    localparam logic C_VS_OFF = ~C_VS_ON;

    logic [CW-1:0]       r_hc;
    logic [CW-1:0]       r_vc;
    logic                r_hsync;
    logic                r_vsync;
    logic                r_de;
    logic [OUT_BITS-1:0] r_red;
    logic [OUT_BITS-1:0] r_green;
    logic [OUT_BITS-1:0] r_blue;
    logic                r_frame_start;
    logic                r_swap_ack;

    logic                w_h_last;
    logic                w_v_last;
    logic                w_active;
    logic                w_hs_on;
    logic                w_vs_on;
    logic                w_first_px;
    logic                w_grant;
    logic [OUT_BITS-1:0] w_red_x;
    logic [OUT_BITS-1:0] w_green_x;
    logic [OUT_BITS-1:0] w_blue_x;

    assign w_h_last   = (r_hc == C_H_LAST);
    assign w_v_last   = (r_vc == C_V_LAST);
    assign w_active   = (r_hc < C_H_ACT) && (r_vc < C_V_ACT);
    assign w_hs_on    = (r_hc >= C_HS_START) && (r_hc < C_HS_END);
    assign w_vs_on    = (r_vc >= C_VS_START) && (r_vc < C_VS_END);
    assign w_first_px = (r_hc == '0) && (r_vc == '0);

    // The grant edge is the one that moves the raster from the last pixel of
    // the last active line into the first line of vertical blank.
    assign w_grant    = w_h_last && (r_vc == C_V_ACT_LAST) && bus.swap_req;

    // Raster counters: hc every clock, vc on each hc wrap.
    always_ff @(posedge vgaclk) begin
        if (rst) begin
            r_hc <= '0;
            r_vc <= '0;
        end else if (w_h_last) begin
            r_hc <= '0;
            r_vc <= w_v_last ? '0 : r_vc + 1'b1;
        end else begin
            r_hc <= r_hc + 1'b1;
        end
    end

    // MSB-first bit replication of each channel up to the DAC width.
    always_comb begin
        w_red_x   = '0;
        w_green_x = '0;
        w_blue_x  = '0;
        for (int i = 0; i < OUT_BITS; i++) begin
            w_red_x[OUT_BITS-1-i]   = bus.input_red[R_IN-1-(i % R_IN)];
            w_green_x[OUT_BITS-1-i] = bus.input_green[G_IN-1-(i % G_IN)];
            w_blue_x[OUT_BITS-1-i]  = bus.input_blue[B_IN-1-(i % B_IN)];
        end
    end

    // Output stage: sync, enable, blanked colour and pulses for the pixel
    // the counters hold on this edge.
    always_ff @(posedge vgaclk) begin
        if (rst) begin
            r_hsync       <= C_HS_OFF;
            r_vsync       <= C_VS_OFF;
            r_de          <= 1'b0;
            r_red         <= '0;
            r_green       <= '0;
            r_blue        <= '0;
            r_frame_start <= 1'b0;
            r_swap_ack    <= 1'b0;
        end else begin
            r_hsync       <= w_hs_on ? C_HS_ON : C_HS_OFF;
            r_vsync       <= w_vs_on ? C_VS_ON : C_VS_OFF;
            r_de          <= w_active;
            r_red         <= w_active ? w_red_x   : '0;
            r_green       <= w_active ? w_green_x : '0;
            r_blue        <= w_active ? w_blue_x  : '0;
            r_frame_start <= w_first_px;
            r_swap_ack    <= w_grant;
        end
    end

    assign bus.hc_out      = r_hc;
    assign bus.vc_out      = r_vc;
    assign bus.hsync       = r_hsync;
    assign bus.vsync       = r_vsync;
    assign bus.de          = r_de;
    assign bus.red         = r_red;
    assign bus.green       = r_green;
    assign bus.blue        = r_blue;
    assign bus.frame_start = r_frame_start;
    assign bus.swap_ack    = r_swap_ack;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: a default 640x480 instance for reset, line timing and
// colour expansion, and a tiny 7x6 raster instance for wrap-around, vsync,
// swap handshake and mid-frame reset, checked against a cycle-count model.
module tb_vga_timing_gen;
    logic clk;
    logic rst_d;
    logic rst_s;

    int errors;
    int checks;

    vga_timing_gen_if #(.CW(10), .R_IN(3), .G_IN(3), .B_IN(2), .OUT_BITS(4)) bus_d ();
    vga_timing_gen_if #(.CW(3),  .R_IN(3), .G_IN(3), .B_IN(2), .OUT_BITS(4)) bus_s ();

    vga_timing_gen u_dut_d (
        .vgaclk (clk),
        .rst    (rst_d),
        .bus    (bus_d.master)
    );

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HSYNC_POL(1)
    ) u_dut_s (
        .vgaclk (clk),
        .rst    (rst_s),
        .bus    (bus_s.master)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    int       hs_low, first_low, last_low, de_cnt, vs_low, he;
    int       m, p, hp, vp;
    logic     req_s, e_req, e_rst;
    logic     x_hs, x_vs, x_de, x_fs, x_ack;
    logic [2:0]  x_hc, x_vc;
    logic [11:0] x_rgb;

    initial begin
        clk    = 1'b0;
        errors = 0;
        checks = 0;
        rst_d  = 1'b1;
        rst_s  = 1'b1;
        req_s  = 1'b0;
        bus_d.input_red   = 3'b101;
        bus_d.input_green = 3'b011;
        bus_d.input_blue  = 2'b10;
        bus_d.swap_req    = 1'b0;
        bus_s.input_red   = 3'b101;
        bus_s.input_green = 3'b011;
        bus_s.input_blue  = 2'b10;
        bus_s.swap_req    = 1'b0;

        // Hold reset three cycles
        tick(); tick(); tick();
        chk("rst_hc",    bus_d.hc_out, 0);
        chk("rst_vc",    bus_d.vc_out, 0);
        chk("rst_hsync", bus_d.hsync, 1);
        chk("rst_vsync", bus_d.vsync, 1);
        chk("rst_de",    bus_d.de, 0);
        chk("rst_rgb",   {bus_d.red, bus_d.green, bus_d.blue}, 12'h000);
        chk("rst_fs",    bus_d.frame_start, 0);
        chk("rst_ack",   bus_d.swap_ack, 0);
        chk("s_rst_hsync", bus_s.hsync, 0);
        chk("s_rst_vsync", bus_s.vsync, 1);

        // Release: first edge samples (0,0), outputs for it appear next
        rst_d = 1'b0;
        chk("rel_hc_before", bus_d.hc_out, 0);
        tick();
        chk("rel_hc",  bus_d.hc_out, 1);
        chk("rel_fs",  bus_d.frame_start, 1);
        chk("rel_de",  bus_d.de, 1);
        chk("rel_rgb", {bus_d.red, bus_d.green, bus_d.blue}, 12'hB6A);
        tick();
        chk("fs_once", bus_d.frame_start, 0);
        chk("hc_2",    bus_d.hc_out, 2);

        // One full line of the default raster
        hs_low = 0; first_low = -1; last_low = -1; de_cnt = 0; vs_low = 0;
        for (int i = 0; i < 800; i++) begin
            tick();
            he = (3 + i) % 800;
            if (bus_d.hsync === 1'b0) begin
                hs_low++;
                if (first_low < 0) first_low = he;
                last_low = he;
            end
            if (bus_d.de === 1'b1) de_cnt++;
            if (bus_d.vsync === 1'b0) vs_low++;
            if (he == 300) begin
                bus_d.input_red   = 3'b111;
                bus_d.input_green = 3'b000;
                bus_d.input_blue  = 2'b01;
            end else if (he == 301) begin
                chk("rgb_pat2", {bus_d.red, bus_d.green, bus_d.blue}, 12'hF05);
                bus_d.input_red   = 3'b101;
                bus_d.input_green = 3'b011;
                bus_d.input_blue  = 2'b10;
            end else if (he == 302) begin
                chk("rgb_pat1", {bus_d.red, bus_d.green, bus_d.blue}, 12'hB6A);
            end else if (he == 701) begin
                chk("blank_h700", {bus_d.red, bus_d.green, bus_d.blue}, 12'h000);
            end
        end
        chk("hs_low_cnt",  hs_low, 96);
        chk("hs_first",    first_low, 657);
        chk("hs_last",     last_low, 752);
        chk("de_cnt",      de_cnt, 640);
        chk("vs_line0",    vs_low, 0);
        chk("line_hc",     bus_d.hc_out, 2);
        chk("line_vc",     bus_d.vc_out, 1);

        // Small raster: H_TOTAL=7, V_TOTAL=6, frame = 42 cycles
        chk("s_hc_start", bus_s.hc_out, 0);
        rst_s = 1'b0;
        m = 0;
        for (int k = 1; k <= 230; k++) begin
            e_req = req_s;
            e_rst = rst_s;
            tick();
            if (e_rst) begin
                m = 0;
                x_hc = 0; x_vc = 0; x_hs = 0; x_vs = 1; x_de = 0;
                x_rgb = 12'h000; x_fs = 0; x_ack = 0;
            end else begin
                m++;
                p  = m - 1;
                hp = p % 7;
                vp = (p / 7) % 6;
                x_hc  = 3'(m % 7);
                x_vc  = 3'((m / 7) % 6);
                x_hs  = (hp == 5);
                x_vs  = (vp == 4) ? 1'b0 : 1'b1;
                x_de  = (hp < 4) && (vp < 3);
                x_rgb = x_de ? 12'hB6A : 12'h000;
                x_fs  = ((p % 42) == 0);
                x_ack = e_req && ((p % 42) == 20);
            end
            chk("s_hc",    bus_s.hc_out, x_hc);
            chk("s_vc",    bus_s.vc_out, x_vc);
            chk("s_hsync", bus_s.hsync, x_hs);
            chk("s_vsync", bus_s.vsync, x_vs);
            chk("s_de",    bus_s.de, x_de);
            chk("s_rgb",   {bus_s.red, bus_s.green, bus_s.blue}, x_rgb);
            chk("s_fs",    bus_s.frame_start, x_fs);
            chk("s_ack",   bus_s.swap_ack, x_ack);

            if (k == 10)  req_s = 1'b1;
            if (k == 21)  req_s = 1'b0;
            if (k == 85)  req_s = 1'b1;
            if (k == 178) rst_s = 1'b1;
            if (k == 190) begin
                rst_s = 1'b0;
                req_s = 1'b0;
            end
            if (k == 200) req_s = 1'b1;
            if (k == 211) req_s = 1'b0;
            bus_s.swap_req = req_s;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA timing generator and pixel output stage; the generalised successor to the fixed 640x480 `vga` block. Sits between the pixel-clock PLL output and the pins. It produces the raster counters consumed by the graphics driver and double buffer. It expands packed RGB input of any per-channel width to the DAC width, blanks outside the active area, and registers sync and colour so they stay aligned. It also provides a vertical-blank buffer-swap handshake so the double buffer flips only between frames.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal front porch, sync width and back porch, in pixel clocks
- V_ACTIVE, 480, visible lines per frame
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical front porch, sync width and back porch, in lines
- HSYNC_POL / VSYNC_POL, 0 / 0, asserted level of each sync (0 = active-low)
- R_IN / G_IN / B_IN, 3 / 3 / 2, input bits per channel (each 1..OUT_BITS)
- OUT_BITS, 4, output bits per channel
- CW, derived: $clog2(max(H_TOTAL, V_TOTAL)), counter width; H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP, V_TOTAL likewise
- vgaclk  in  1  pixel clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- input_red / input_green / input_blue  in  R_IN / G_IN / B_IN  pixel colour for the current hc_out/vc_out
- swap_req  in  1  level; buffer-swap request from the writer
- hc_out / vc_out  out  CW  current horizontal / vertical counter
- hsync / vsync  out  1  sync outputs, registered
- de  out  1  data enable (active video), registered
- red / green / blue  out  OUT_BITS  expanded, blanked colour, registered
- frame_start  out  1  one-cycle pulse aligned with the first active pixel of a frame on the outputs
- swap_ack  out  1  one-cycle pulse granting a swap

## Operation
- Counters: hc increments every clock and wraps from H_TOTAL-1 to 0. vc increments when hc wraps and wraps from V_TOTAL-1 to 0. Both are unsigned, CW wide, and never exceed TOTAL-1.
- active = (hc < H_ACTIVE) && (vc < V_ACTIVE).
- hsync is asserted when H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC. vsync is asserted when V_ACTIVE+V_FP <= vc < V_ACTIVE+V_FP+V_SYNC. vsync depends on vc only, not hc.
- Asserted level = *_POL. Deasserted level = ~*_POL.
- Colour expansion uses MSB-first bit replication of the input, truncated to OUT_BITS.
  - 3-bit 3'b101 becomes 4'b1011.
  - 2-bit 2'b10 becomes 4'b1010.
  - When IN == OUT_BITS, the input passes through unchanged.
- Outside active, red, green and blue are forced to 0 whatever the inputs are.
- Swap handshake:
  - The grant point is the counter transition from (hc=H_TOTAL-1, vc=V_ACTIVE-1) to (0, V_ACTIVE), i.e. the start of vertical blank.
  - If swap_req is high on the clock edge that performs this transition, swap_ack pulses high for the following single cycle.
  - The requester holds swap_req until it sees swap_ack. A request raised mid-frame waits for the next grant point.
  - At most one ack is issued per frame. A still-high swap_req produces the next ack one frame later.
- frame_start is high for exactly one cycle per frame, in the same cycle that de first goes high for line 0.

## Timing
- Reset, on the first edge with rst high:
  - hc = vc = 0
  - hsync = ~HSYNC_POL, vsync = ~VSYNC_POL
  - de = 0; red = green = blue = 0
  - frame_start = 0, swap_ack = 0
  - These values hold while rst stays high.
- Reset mid-frame aborts the frame immediately. No ack or frame_start is emitted during reset. A request pending at reset is dropped; swap_req must be re-presented after reset.
- After rst falls: the first edge samples counters (0,0). Outputs for pixel (0,0) appear one cycle later, with frame_start = 1.
- Latency: hc_out/vc_out are the counter registers. Input colour is sampled on the same edge the counters advance. hsync, vsync, de, red/green/blue and frame_start show pixel (hc,vc) exactly 1 cycle after hc_out/vc_out showed it. Sync is therefore never skewed against colour.
- swap_ack is registered: high during the cycle in which hc_out=0, vc_out=V_ACTIVE.
- Simultaneous events: a grant point coinciding with swap_req rising on that edge is granted. Counter wrap and frame_start have no interaction with the handshake beyond the grant point.

## Test plan
- Reset check: hold rst 3 cycles with default params -> hc_out = vc_out = 0, hsync = vsync = 1, de = 0, colour 0, no pulses. Release -> frame_start = 1 exactly one cycle after release + 1.
- Default line timing: count cycles -> hsync low for 96 cycles, with output low while hc_out = 657..752. de high for 640 consecutive cycles. Period 800. vsync low for exactly 2 full lines (1600 cycles). Frame = 525 lines.
- Expansion and blanking: input RGB = 3'b101, 3'b011, 2'b10 at an active pixel -> red = 4'hB, green = 4'h6, blue = 4'hA. Same input at hc = 700 -> all 0.
- Small config, for fast wrap-around: H_ACTIVE=4, H_FP=H_SYNC=H_BP=1, V_ACTIVE=3, V_FP=V_SYNC=V_BP=1, HSYNC_POL=1.
  - hc sequence 0..6,0 is observed.
  - hsync output is high only for hc_out = 5 registered, i.e. the cycle after hc_out = 5.
  - vc wraps 5 -> 0.
- Swap handshake:
  - Raise swap_req at vc = 100 -> swap_ack single pulse when hc_out=0, vc_out=480. Drop req -> no ack in the next frame.
  - Hold req -> one ack per frame.
- Reset mid-frame at vc = 200 with swap_req high -> outputs return to reset values the next cycle. The counters restart at (0,0) and no swap_ack is produced during reset.
